collision_arbiter: RTL and testbench
====================================

COLLISION_ARBITER -- requirements
Module: collision_arbiter

Interface
REQ-001 Parameter SETTLE, default 1: extra wait cycles between probe issue and result sample (range 0..7).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  4  per-requester probe request (0 = pacman, 1..3 = ghosts); level, held until ack.
REQ-005 dir_bus  input  16  requester i direction in bits [4i+3:4i], one-hot (1000 left, 0100 up, 0010 right, 0001 down).
REQ-006 px_bus  input  36  requester i x position in bits [9i+8:9i].
REQ-007 py_bus  input  36  requester i y position in bits [9i+8:9i].
REQ-008 ack  output  4  one-hot, one-cycle pulse to the served requester; blocked is valid in the same cycle.
REQ-009 blocked  output  1  probe result, 1 = move into wall; held until next ack.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 chk_dir  output  4  direction to the shared collision checker.
REQ-012 chk_x, chk_y  output  9 each  probe position to the shared collision checker.
REQ-013 chk_collide  input  1  checker result; valid from the second clock edge after chk_* become stable.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, SAMPLE.
REQ-015 In IDLE with any req bit high, the block SHALL grant one requester by round-robin starting at (last_grant+1) mod 4, latch its dir/x/y, and go to ISSUE next cycle.
REQ-016 In IDLE with req = 0, the block SHALL stay in IDLE with ack = 0.
REQ-017 If the latched direction is not one-hot, the block SHALL skip the probe, return to IDLE, and pulse ack with blocked = 1 in the cycle after the grant.
REQ-018 ISSUE SHALL last exactly one cycle with chk_* driven from the latched request; the checker registers its probe points on that cycle's closing edge.
REQ-019 WAIT SHALL last SETTLE cycles via a 3-bit counter; SETTLE = 0 SHALL go directly from ISSUE to SAMPLE.
REQ-020 chk_dir, chk_x, chk_y SHALL hold constant from ISSUE through SAMPLE.
REQ-021 In SAMPLE the block SHALL register chk_collide into blocked, pulse ack for the granted requester, update last_grant, and return to IDLE.
REQ-022 Grant-to-ack latency SHALL be 2+SETTLE cycles for a valid probe (IDLE grant cycle excluded).
REQ-023 Requests arriving while busy SHALL wait; no request SHALL be dropped while its req stays high.
REQ-024 A requester dropping req mid-operation SHALL NOT abort the operation; ack is still pulsed.
REQ-025 A requester keeping req high after ack SHALL be re-arbitrated after all other pending requesters (fairness bound: 4 operations).
REQ-026 ack and blocked SHALL come from registers, not combinational paths.
REQ-027 Positions SHALL pass through unmodified (9-bit); the checker applies the step offsets and wrap-around.

Reset
REQ-028 While rst_n = 0: state = IDLE, ack = 0, blocked = 0, busy = 0, chk_dir = 0000, chk_x = chk_y = 0, WAIT counter = 0, last_grant = 3 so requester 0 wins first.
REQ-029 Reset asserted mid-operation SHALL abandon the probe with no ack; arbitration restarts after release.

Verification
REQ-030 Single request: req = 0001, dir 0010, x = 100, y = 50, SETTLE = 1, chk_collide = 1 -> chk_* = (0010,100,50) from ISSUE; ack = 0001 with blocked = 1 exactly 3 cycles after grant.
REQ-031 All four requesting continuously -> acks in order 0,1,2,3,0; each ack one cycle; busy low for one IDLE cycle between operations.
REQ-032 Invalid direction: req = 0100, requester 2 dir = 0110 -> ack = 0100, blocked = 1 one cycle after grant; chk_* unchanged.
REQ-033 SETTLE = 0 and SETTLE = 3 -> ack at 2 and 5 cycles after grant respectively; blocked equals chk_collide sampled in SAMPLE.
REQ-034 Reset during WAIT -> all outputs at reset values immediately, no ack; after release, req = 1000 is served first by requester 3 with normal latency.
REQ-035 Requester 1 drops req during ISSUE -> ack = 0010 still pulses; next grant goes to lowest-ranked pending requester after 1.

Source files
------------

// File: rtl/collision_arbiter.sv
// Collision arbiter: serialises movement probes from pacman and three ghosts
// onto a single shared wall-collision checker. A round-robin arbiter picks one
// requester, the probe is presented to the checker, the result is sampled after
// the checker's pipeline has settled, and the requester is acknowledged.
module collision_arbiter #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] dir_bus,
  input  logic [35:0] px_bus,
  input  logic [35:0] py_bus,
  output logic [3:0]  ack,
  output logic        blocked,
  output logic        busy,
  output logic [3:0]  chk_dir,
  output logic [8:0]  chk_x,
  output logic [8:0]  chk_y,
  input  logic        chk_collide
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    SAMPLE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  dir_q, dir_d;
  logic [8:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [3:0]  ack_q, ack_d;
  logic        blocked_q, blocked_d;

  logic [3:0]  dir_arr [4];
  logic [8:0]  x_arr [4];
  logic [8:0]  y_arr [4];

  logic [1:0]  rr_cand;
  logic [1:0]  rr_sel;
  logic        rr_found;
  logic [3:0]  sel_dir;
  logic        sel_dir_ok;

  // Split the packed per-requester buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dir_arr[i] = dir_bus[4*i +: 4];
      x_arr[i]   = px_bus[9*i +: 9];
      y_arr[i]   = py_bus[9*i +: 9];
    end
  end

  // Round-robin pick: search from the requester after the last one served.
  always_comb begin
    rr_cand  = '0;
    rr_sel   = last_q;
    rr_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last_q + 2'(k);
      if (!rr_found && req[rr_cand]) begin
        rr_sel   = rr_cand;
        rr_found = 1'b1;
      end
    end
    sel_dir    = dir_arr[rr_sel];
    sel_dir_ok = (sel_dir != 4'd0) && ((sel_dir & (sel_dir - 4'd1)) == 4'd0);
  end

  // Next-state logic: arbitration, probe sequencing and registered responses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    ack_d     = 4'd0;
    blocked_d = blocked_q;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          gnt_d = rr_sel;
          if (sel_dir_ok) begin
            dir_d   = sel_dir;
            x_d     = x_arr[rr_sel];
            y_d     = y_arr[rr_sel];
            state_d = ISSUE;
          end else begin
            // A malformed direction can never be a legal move: answer
            // "blocked" right away without disturbing the checker inputs.
            ack_d     = 4'b0001 << rr_sel;
            blocked_d = 1'b1;
            last_d    = rr_sel;
          end
        end
      end

      ISSUE: begin
        cnt_d = 3'd0;
        if (SETTLE == 0) begin
          ack_d     = 4'b0001 << gnt_q;
          blocked_d = chk_collide;
          last_d    = gnt_q;
          state_d   = SAMPLE;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == 3'(SETTLE - 1)) begin
          cnt_d     = 3'd0;
          ack_d     = 4'b0001 << gnt_q;
          blocked_d = chk_collide;
          last_d    = gnt_q;
          state_d   = SAMPLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      SAMPLE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; last grant resets to 3 so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      gnt_q     <= 2'd0;
      last_q    <= 2'd3;
      dir_q     <= 4'd0;
      x_q       <= 9'd0;
      y_q       <= 9'd0;
      ack_q     <= 4'd0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ack_q     <= ack_d;
      blocked_q <= blocked_d;
    end
  end

  assign ack     = ack_q;
  assign blocked = blocked_q;
  assign busy    = (state_q != IDLE);
  assign chk_dir = dir_q;
  assign chk_x   = x_q;
  assign chk_y   = y_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// Testbench for collision_arbiter: a table of single probes plus hand-written
// multi-cycle sequences, with a scoreboard of expected acknowledges.
module tb_collision_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] dir_bus;
  logic [35:0] px_bus;
  logic [35:0] py_bus;
  logic [3:0]  ack;
  logic        blocked;
  logic        busy;
  logic [3:0]  chk_dir;
  logic [8:0]  chk_x;
  logic [8:0]  chk_y;
  logic        chk_collide;

  logic [3:0]  req_s0, ack_s0, chk_dir_s0;
  logic        blocked_s0, busy_s0, chk_collide_s0;
  logic [8:0]  chk_x_s0, chk_y_s0;
  logic [3:0]  req_s3, ack_s3, chk_dir_s3;
  logic        blocked_s3, busy_s3, chk_collide_s3;
  logic [8:0]  chk_x_s3, chk_y_s3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] ack;
    logic       blocked;
    int         due;
    logic [3:0] cdir;
    logic [8:0] cx;
    logic [8:0] cy;
  } sb_t;

  sb_t sb[$];

  typedef struct {
    int         idx;
    logic [3:0] dir;
    logic [8:0] x;
    logic [8:0] y;
    logic       exp_blocked;
    int         exp_lat;
  } vec_t;

  vec_t vecs [8];

  logic [3:0] lc_dir;
  logic [8:0] lc_x;
  logic [8:0] lc_y;

  // Bench model of the wall checker: a wall wherever the probe bits have odd parity.
  function automatic logic wall(input logic [3:0] d, input logic [8:0] x, input logic [8:0] y);
    return ^{d, x, y};
  endfunction

  assign chk_collide    = wall(chk_dir, chk_x, chk_y);
  assign chk_collide_s0 = wall(chk_dir_s0, chk_x_s0, chk_y_s0);
  assign chk_collide_s3 = wall(chk_dir_s3, chk_x_s3, chk_y_s3);

  collision_arbiter #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dir_bus(dir_bus), .px_bus(px_bus),
    .py_bus(py_bus), .ack(ack), .blocked(blocked), .busy(busy), .chk_dir(chk_dir),
    .chk_x(chk_x), .chk_y(chk_y), .chk_collide(chk_collide)
  );

  collision_arbiter #(.SETTLE(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .req(req_s0), .dir_bus(dir_bus), .px_bus(px_bus),
    .py_bus(py_bus), .ack(ack_s0), .blocked(blocked_s0), .busy(busy_s0), .chk_dir(chk_dir_s0),
    .chk_x(chk_x_s0), .chk_y(chk_y_s0), .chk_collide(chk_collide_s0)
  );

  collision_arbiter #(.SETTLE(3)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .req(req_s3), .dir_bus(dir_bus), .px_bus(px_bus),
    .py_bus(py_bus), .ack(ack_s3), .blocked(blocked_s3), .busy(busy_s3), .chk_dir(chk_dir_s3),
    .chk_x(chk_x_s3), .chk_y(chk_y_s3), .chk_collide(chk_collide_s3)
  );

  // Free-running clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [3:0] d, input logic [8:0] x,
                               input logic [8:0] y);
    dir_bus[4*idx +: 4] = d;
    px_bus[9*idx +: 9]  = x;
    py_bus[9*idx +: 9]  = y;
  endtask

  task automatic pushExpect(input int idx, input logic blk, input int due, input logic valid,
                            input logic [3:0] d, input logic [8:0] x, input logic [8:0] y);
    sb_t e;
    e.ack     = 4'b0001 << idx;
    e.blocked = blk;
    e.due     = due;
    if (valid) begin
      lc_dir = d;
      lc_x   = x;
      lc_y   = y;
    end
    e.cdir = lc_dir;
    e.cx   = lc_x;
    e.cy   = lc_y;
    sb.push_back(e);
  endtask

  task automatic drainScoreboard(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("ack_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Scoreboard monitor: every ack pulse of the main instance must match the queue head.
  always @(negedge clk) begin
    if (ack !== 4'd0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        checkOutput("ack", 32'(ack), 32'(e.ack));
        checkOutput("blocked", 32'(blocked), 32'(e.blocked));
        checkOutput("ack_cycle", 32'(cyc), 32'(e.due));
        checkOutput("chk_dir_at_ack", 32'(chk_dir), 32'(e.cdir));
        checkOutput("chk_x_at_ack", 32'(chk_x), 32'(e.cx));
        checkOutput("chk_y_at_ack", 32'(chk_y), 32'(e.cy));
      end
    end
  end

  initial begin
    int c;
    int lowcnt;
    int lat0, lat3;
    logic [3:0] a0, a3;
    logic b0, b3;
    logic [3:0] sdir [2];
    logic [8:0] sx [2];
    logic [8:0] sy [2];
    int sidx [2];

    vecs[0] = '{0, 4'b0010, 9'd100, 9'd50,  1'b1, 3};
    vecs[1] = '{2, 4'b0110, 9'd7,   9'd7,   1'b1, 1};
    vecs[2] = '{3, 4'b0001, 9'd511, 9'd0,   1'b0, 3};
    vecs[3] = '{1, 4'b0100, 9'd1,   9'd0,   1'b0, 3};
    vecs[4] = '{2, 4'b0001, 9'd256, 9'd511, 1'b1, 3};
    vecs[5] = '{3, 4'b1111, 9'd5,   9'd6,   1'b1, 1};
    vecs[6] = '{1, 4'b1000, 9'd0,   9'd0,   1'b1, 3};
    vecs[7] = '{0, 4'b0000, 9'd3,   9'd3,   1'b1, 1};

    rst_n   = 1'b0;
    req     = 4'd0;
    req_s0  = 4'd0;
    req_s3  = 4'd0;
    dir_bus = '0;
    px_bus  = '0;
    py_bus  = '0;
    lc_dir  = 4'd0;
    lc_x    = 9'd0;
    lc_y    = 9'd0;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_blocked", 32'(blocked), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_chk_dir", 32'(chk_dir), 32'd0);
    checkOutput("rst_chk_x", 32'(chk_x), 32'd0);
    checkOutput("rst_chk_y", 32'(chk_y), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("idle_no_req_busy", 32'(busy), 32'd0);

    // All four requesting continuously: strict rotation starting at requester 0.
    applyStimulus(0, 4'b0010, 9'd10, 9'd20);
    applyStimulus(1, 4'b0100, 9'd30, 9'd40);
    applyStimulus(2, 4'b1000, 9'd50, 9'd60);
    applyStimulus(3, 4'b0001, 9'd70, 9'd80);
    req = 4'b1111;
    c = cyc;
    pushExpect(0, wall(4'b0010, 9'd10, 9'd20), c + 3,  1'b1, 4'b0010, 9'd10, 9'd20);
    pushExpect(1, wall(4'b0100, 9'd30, 9'd40), c + 7,  1'b1, 4'b0100, 9'd30, 9'd40);
    pushExpect(2, wall(4'b1000, 9'd50, 9'd60), c + 11, 1'b1, 4'b1000, 9'd50, 9'd60);
    pushExpect(3, wall(4'b0001, 9'd70, 9'd80), c + 15, 1'b1, 4'b0001, 9'd70, 9'd80);
    pushExpect(0, wall(4'b0010, 9'd10, 9'd20), c + 19, 1'b1, 4'b0010, 9'd10, 9'd20);
    lowcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (sb.size() > 0 && sb.size() < 5 && !busy) lowcnt++;
      if (sb.size() == 0) break;
    end
    req = 4'd0;
    checkOutput("rr_done", 32'(sb.size()), 32'd0);
    sb.delete();
    checkOutput("rr_idle_gaps", 32'(lowcnt), 32'd4);

    // Table of single probes with the default settle time.
    for (int v = 0; v < 8; v++) begin
      logic valid;
      valid = (vecs[v].exp_lat != 1);
      @(negedge clk);
      #1;
      applyStimulus(vecs[v].idx, vecs[v].dir, vecs[v].x, vecs[v].y);
      req = 4'b0001 << vecs[v].idx;
      pushExpect(vecs[v].idx, vecs[v].exp_blocked, cyc + vecs[v].exp_lat, valid,
                 vecs[v].dir, vecs[v].x, vecs[v].y);
      @(negedge clk);
      #1;
      checkOutput($sformatf("vec%0d_busy", v), 32'(busy), 32'(valid));
      if (valid) begin
        checkOutput($sformatf("vec%0d_issue_dir", v), 32'(chk_dir), 32'(vecs[v].dir));
        checkOutput($sformatf("vec%0d_issue_x", v), 32'(chk_x), 32'(vecs[v].x));
        checkOutput($sformatf("vec%0d_issue_y", v), 32'(chk_y), 32'(vecs[v].y));
      end
      drainScoreboard(20);
      req = 4'd0;
    end

    // Settle-time variants: latency 2 with SETTLE=0 and 5 with SETTLE=3.
    sidx[0] = 1; sdir[0] = 4'b0010; sx[0] = 9'd100; sy[0] = 9'd50;
    sidx[1] = 2; sdir[1] = 4'b0100; sx[1] = 9'd9;   sy[1] = 9'd200;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      #1;
      applyStimulus(sidx[s], sdir[s], sx[s], sy[s]);
      req_s0 = 4'b0001 << sidx[s];
      req_s3 = 4'b0001 << sidx[s];
      c = cyc;
      lat0 = -1; lat3 = -1; a0 = 4'd0; a3 = 4'd0; b0 = 1'bx; b3 = 1'bx;
      fork
        begin
          for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ack_s0 != 4'd0) begin
              lat0 = cyc - c; a0 = ack_s0; b0 = blocked_s0; req_s0 = 4'd0;
              break;
            end
          end
        end
        begin
          for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ack_s3 != 4'd0) begin
              lat3 = cyc - c; a3 = ack_s3; b3 = blocked_s3; req_s3 = 4'd0;
              break;
            end
          end
        end
      join
      req_s0 = 4'd0;
      req_s3 = 4'd0;
      checkOutput($sformatf("s0_latency%0d", s), 32'(lat0), 32'd2);
      checkOutput($sformatf("s3_latency%0d", s), 32'(lat3), 32'd5);
      checkOutput($sformatf("s0_ack%0d", s), 32'(a0), 32'(4'b0001 << sidx[s]));
      checkOutput($sformatf("s3_ack%0d", s), 32'(a3), 32'(4'b0001 << sidx[s]));
      checkOutput($sformatf("s0_blocked%0d", s), 32'(b0), 32'(wall(sdir[s], sx[s], sy[s])));
      checkOutput($sformatf("s3_blocked%0d", s), 32'(b3), 32'(wall(sdir[s], sx[s], sy[s])));
    end

    // Requester 1 withdraws during ISSUE; it is still acked, then 2 and 3 follow.
    @(negedge clk);
    #1;
    applyStimulus(1, 4'b0001, 9'd11, 9'd22);
    applyStimulus(2, 4'b0010, 9'd33, 9'd44);
    applyStimulus(3, 4'b0100, 9'd55, 9'd66);
    req = 4'b1110;
    c = cyc;
    pushExpect(1, wall(4'b0001, 9'd11, 9'd22), c + 3,  1'b1, 4'b0001, 9'd11, 9'd22);
    pushExpect(2, wall(4'b0010, 9'd33, 9'd44), c + 7,  1'b1, 4'b0010, 9'd33, 9'd44);
    pushExpect(3, wall(4'b0100, 9'd55, 9'd66), c + 11, 1'b1, 4'b0100, 9'd55, 9'd66);
    @(negedge clk);
    #1;
    checkOutput("drop_busy_in_issue", 32'(busy), 32'd1);
    req = 4'b1100;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 1) req = 4'b1000;
      if (sb.size() == 0) break;
    end
    req = 4'd0;
    checkOutput("drop_done", 32'(sb.size()), 32'd0);
    sb.delete();

    // Reset asserted while waiting on the checker: probe abandoned, no ack.
    @(negedge clk);
    #1;
    applyStimulus(0, 4'b0010, 9'd12, 9'd34);
    req = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ack", 32'(ack), 32'd0);
    checkOutput("midrst_blocked", 32'(blocked), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_chk_dir", 32'(chk_dir), 32'd0);
    checkOutput("midrst_chk_x", 32'(chk_x), 32'd0);
    checkOutput("midrst_chk_y", 32'(chk_y), 32'd0);
    req = 4'd0;
    lc_dir = 4'd0;
    lc_x   = 9'd0;
    lc_y   = 9'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    applyStimulus(3, 4'b1000, 9'd77, 9'd88);
    req = 4'b1000;
    pushExpect(3, wall(4'b1000, 9'd77, 9'd88), cyc + 3, 1'b1, 4'b1000, 9'd77, 9'd88);
    drainScoreboard(20);
    req = 4'd0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
